// File: rtl/ps2_voice_scheduler_pkg.sv
// ============================================================================
// ps2_voice_scheduler_pkg : scan-code constants, decoder states, event record
// Revision 1.0
// ============================================================================
`default_nettype none

package ps2_voice_scheduler_pkg;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_TIMEOUT    = 200000;
    localparam int VIDX_W         = 2;
    localparam int TO_W           = 18;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef struct packed {
        logic [7:0]        code;
        logic              press;
        logic [VIDX_W-1:0] voice;
        logic              steal;
    } evt_t;

    // Controller/status bytes that never represent a key.
    function automatic logic is_discard(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
// ============================================================================
// ps2_evt_fifo : 2-entry first-word-fall-through event queue, sticky overflow
// Revision 1.0
// ============================================================================
`default_nettype none

module ps2_evt_fifo
    import ps2_voice_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  evt_t push_evt_i,
    input  logic ready_i,
    output logic valid_o,
    output evt_t head_o,
    output logic overflow_o
);

    logic [1:0] count_q, count_d;
    evt_t       head_q, head_d;
    evt_t       tail_q, tail_d;
    logic       ovf_q, ovf_d;
    logic       pop;

    assign pop = (count_q != 2'd0) && ready_i;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        ovf_d   = ovf_q;
        case ({push_i, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = push_evt_i;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    tail_d  = push_evt_i;
                    count_d = 2'd2;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Pop implies non-empty, so occupancy is unchanged.
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_evt_i;
                end else begin
                    head_d = push_evt_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o    = (count_q != 2'd0);
    assign head_o     = head_q;
    assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/ps2_voice_scheduler.sv
// ============================================================================
// ps2_voice_scheduler : PS/2 scan-code decoder with rank-based voice allocation
// Revision 1.0
// ============================================================================
`default_nettype none

module ps2_voice_scheduler
    import ps2_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [8*NUM_VOICES-1:0] voice_key,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [7:0]              evt_code,
    output logic                    evt_press,
    output logic [VIDX_W-1:0]       evt_voice,
    output logic                    evt_steal,
    output logic                    evt_overflow
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    logic [1:0]                  state_q, state_d;
    logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
    logic                        to_expire;
    logic [NUM_VOICES-1:0][7:0]  key_q, key_d;
    logic [NUM_VOICES-1:0]       active_q, active_d;
    logic [NUM_VOICES-1:0][1:0]  rank_q, rank_d;

    logic                        is_make, is_brk;
    logic                        hit, free_any, old_found;
    logic [VIDX_W-1:0]           hit_idx, free_idx, old_idx, alloc_idx;
    logic [1:0]                  old_rank;
    logic                        push;
    evt_t                        push_evt, head;

    // Idle counter runs in every state; only non-IDLE states act on it.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (rx_valid) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign to_expire = !rx_valid && (to_cnt_d >= TO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end
                end
                ST_EXT:  state_d = (rx_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if (to_expire && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        is_make = 1'b0;
        is_brk  = 1'b0;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: is_make = (rx_data != SC_BREAK) && (rx_data != SC_EXT)
                                   && !is_discard(rx_data);
                ST_BRK:  is_brk  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active_q[i] && (key_q[i] == rx_data)) begin
                hit     = 1'b1;
                hit_idx = VIDX_W'(i);
            end
            if (!active_q[i]) begin
                free_any = 1'b1;
                free_idx = VIDX_W'(i);
            end
        end
    end

    // Strict compare while scanning upward keeps ties on the lowest index.
    always_comb begin
        old_found = 1'b0;
        old_idx   = '0;
        old_rank  = 2'd0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i] && (!old_found || (rank_q[i] > old_rank))) begin
                old_found = 1'b1;
                old_idx   = VIDX_W'(i);
                old_rank  = rank_q[i];
            end
        end
    end

    assign alloc_idx = free_any ? free_idx : old_idx;

    always_comb begin
        key_d    = key_q;
        active_d = active_q;
        rank_d   = rank_q;
        push     = 1'b0;
        push_evt = '0;
        if (is_make && !hit) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if ((VIDX_W'(i) != alloc_idx) && active_q[i] && (rank_q[i] != 2'd3)) begin
                    rank_d[i] = rank_q[i] + 2'd1;
                end
            end
            key_d[alloc_idx]    = rx_data;
            active_d[alloc_idx] = 1'b1;
            rank_d[alloc_idx]   = 2'd0;
            push                = 1'b1;
            push_evt.code       = rx_data;
            push_evt.press      = 1'b1;
            push_evt.voice      = alloc_idx;
            push_evt.steal      = !free_any;
        end else if (is_brk && hit) begin
            active_d[hit_idx] = 1'b0;
            push              = 1'b1;
            push_evt.code     = rx_data;
            push_evt.press    = 1'b0;
            push_evt.voice    = hit_idx;
            push_evt.steal    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            active_q <= '0;
            rank_q   <= '0;
        end else begin
            key_q    <= key_d;
            active_q <= active_d;
            rank_q   <= rank_d;
        end
    end

    ps2_evt_fifo u_evt_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_evt_i (push_evt),
        .ready_i    (evt_ready),
        .valid_o    (evt_valid),
        .head_o     (head),
        .overflow_o (evt_overflow)
    );

    assign voice_key    = key_q;
    assign voice_active = active_q;
    assign evt_code     = head.code;
    assign evt_press    = head.press;
    assign evt_voice    = head.voice;
    assign evt_steal    = head.steal;

endmodule

`default_nettype wire

// File: tb/tb_ps2_voice_scheduler.sv
// ============================================================================
// tb_ps2_voice_scheduler : directed stimulus, spec-level model, per-cycle check
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ps2_voice_scheduler;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        evt_ready = 1'b0;
    logic [31:0] voice_key;
    logic [3:0]  voice_active;
    logic        evt_valid;
    logic [7:0]  evt_code;
    logic        evt_press;
    logic [1:0]  evt_voice;
    logic        evt_steal;
    logic        evt_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_voice_scheduler #(.NUM_VOICES(4), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .voice_key    (voice_key),
        .voice_active (voice_active),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_press    (evt_press),
        .evt_voice    (evt_voice),
        .evt_steal    (evt_steal),
        .evt_overflow (evt_overflow)
    );

    initial forever #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] code;
        logic       press;
        logic [1:0] voice;
        logic       steal;
    } ev_t;

    logic [7:0] mkey [4];
    bit         mact [4];
    int         mrank[4];
    ev_t        mq[$];
    bit         movf;
    int         mmode;   // 0 idle, 1 after F0, 2 after E0, 3 after E0 F0
    int         midle;

    function automatic bit discard(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mkey[i] = 8'h00; mact[i] = 0; mrank[i] = 0;
        end
        mq.delete();
        movf = 0; mmode = 0; midle = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit rdy);
        bit  pop;
        bit  push;
        ev_t e;
        int  a;
        pop  = (mq.size() > 0) && rdy;
        push = 0;
        e    = '{8'h00, 1'b0, 2'd0, 1'b0};
        if (v) begin
            midle = 0;
            if (mmode == 0) begin
                if (d == 8'hF0) mmode = 1;
                else if (d == 8'hE0) mmode = 2;
                else if (!discard(d)) begin
                    a = -1;
                    for (int i = 0; i < 4; i++) if (mact[i] && mkey[i] == d) a = 99;
                    if (a != 99) begin
                        for (int i = 3; i >= 0; i--) if (!mact[i]) a = i;
                        e.steal = (a < 0);
                        if (a < 0) begin
                            a = 0;
                            for (int i = 1; i < 4; i++) if (mrank[i] > mrank[a]) a = i;
                        end
                        for (int i = 0; i < 4; i++)
                            if (i != a && mact[i] && mrank[i] < 3) mrank[i]++;
                        mkey[a] = d; mact[a] = 1; mrank[a] = 0;
                        e.code = d; e.press = 1; e.voice = 2'(a);
                        push = 1;
                    end
                end
            end else if (mmode == 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (!push && mact[i] && mkey[i] == d) begin
                        mact[i] = 0;
                        e.code = d; e.press = 0; e.voice = 2'(i);
                        push = 1;
                    end
                end
                mmode = 0;
            end else if (mmode == 2) begin
                mmode = (d == 8'hF0) ? 3 : 0;
            end else begin
                mmode = 0;
            end
        end else begin
            if (midle < 1000000) midle++;
            if (midle >= TO) mmode = 0;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < 2) mq.push_back(e);
            else movf = 1;
        end
    endtask

    function automatic logic [31:0] exp_keys();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = mkey[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_act();
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4; i++) r[i] = mact[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("voice_key", voice_key, exp_keys());
            chk("voice_active", 32'(voice_active), exp_act());
            chk("evt_valid", 32'(evt_valid), 32'(mq.size() > 0));
            chk("evt_overflow", 32'(evt_overflow), 32'(movf));
            if (mq.size() > 0) begin
                chk("evt_code", 32'(evt_code), 32'(mq[0].code));
                chk("evt_press", 32'(evt_press), 32'(mq[0].press));
                chk("evt_voice", 32'(evt_voice), 32'(mq[0].voice));
                chk("evt_steal", 32'(evt_steal), 32'(mq[0].steal));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(rx_valid, rx_data, evt_ready);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_head(input string name, input logic [7:0] c, input logic p,
                            input logic [1:0] v, input logic s);
        chk({name, "_valid"}, 32'(evt_valid), 32'd1);
        chk({name, "_code"},  32'(evt_code),  32'(c));
        chk({name, "_press"}, 32'(evt_press), 32'(p));
        chk({name, "_voice"}, 32'(evt_voice), 32'(v));
        chk({name, "_steal"}, 32'(evt_steal), 32'(s));
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("rst_active", 32'(voice_active), 32'd0);
        chk("rst_key", voice_key, 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_head", {20'd0, evt_code, evt_press, evt_voice, evt_steal}, 32'd0);
        chk("rst_ovf", 32'(evt_overflow), 32'd0);

        // two presses, typematic repeat, release
        evt_ready = 1'b1;
        send(8'h1C); chk_head("p1C", 8'h1C, 1'b1, 2'd0, 1'b0);
        send(8'h1B); chk_head("p1B", 8'h1B, 1'b1, 2'd1, 1'b0);
        idle(1);
        chk("act_0011", 32'(voice_active), 32'h3);
        send(8'h1C); chk("rep1_valid", 32'(evt_valid), 32'd0);
        send(8'h1C); chk("rep2_valid", 32'(evt_valid), 32'd0);
        send(8'hF0); send(8'h1C); chk_head("r1C", 8'h1C, 1'b0, 2'd0, 1'b0);
        chk("act_0010", 32'(voice_active), 32'h2);
        chk("key_kept", 32'(voice_key[7:0]), 32'h1C);
        send(8'hF0); send(8'h77); idle(1);
        chk("brk_unheld", 32'(evt_valid), 32'd0);

        // steal the oldest voice
        do_reset();
        chk("rst2_head", {20'd0, evt_code, evt_press, evt_voice, evt_steal}, 32'd0);
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        send(8'h2C); chk_head("steal", 8'h2C, 1'b1, 2'd0, 1'b1);
        chk("steal_key", 32'(voice_key[7:0]), 32'h2C);
        chk("steal_act", 32'(voice_active), 32'hF);

        // rank saturation produces a tie resolved to the lowest index
        do_reset();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        send(8'hF0); send(8'h2D);
        send(8'h2C); chk_head("free3", 8'h2C, 1'b1, 2'd3, 1'b0);
        send(8'hF0); send(8'h2C);
        send(8'h2B);
        send(8'h34); chk_head("tie0", 8'h34, 1'b1, 2'd0, 1'b1);
        send(8'h35); chk_head("next1", 8'h35, 1'b1, 2'd1, 1'b1);

        // extended keys and discards
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hAA); send(8'hFA); send(8'h00);
        idle(1);
        chk("ext_valid", 32'(evt_valid), 32'd0);
        chk("ext_act", 32'(voice_active), 32'd0);

        // overflow with the consumer stalled
        do_reset();
        evt_ready = 1'b0;
        send(8'h11); send(8'h12); send(8'h13);
        chk_head("ovf_head", 8'h11, 1'b1, 2'd0, 1'b0);
        chk("ovf_flag", 32'(evt_overflow), 32'd1);
        chk("ovf_act", 32'(voice_active), 32'h7);
        idle(2);
        evt_ready = 1'b1;
        tick(); chk("pop1_code", 32'(evt_code), 32'h12);
        tick(); chk("pop2_valid", 32'(evt_valid), 32'd0);
        chk("ovf_sticky", 32'(evt_overflow), 32'd1);

        // push and pop together while full
        do_reset();
        evt_ready = 1'b0;
        send(8'h21); send(8'h22);
        evt_ready = 1'b1;
        send(8'h23);
        chk("pp_ovf", 32'(evt_overflow), 32'd0);
        chk("pp_code", 32'(evt_code), 32'h22);
        idle(3);

        // timeout boundary
        do_reset();
        send(8'hF0); idle(TO - 1); send(8'h1C); idle(1);
        chk("to_short", 32'(evt_valid), 32'd0);
        send(8'hF0); idle(TO); send(8'h1C);
        chk_head("to_full", 8'h1C, 1'b1, 2'd0, 1'b0);

        // reset mid-prefix
        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        chk_head("rst_prefix", 8'h1C, 1'b1, 2'd0, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/ps2_voice_scheduler.md
PS2_VOICE_SCHEDULER -- requirements
Module: ps2_voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of voice slots (fixed at 4 for this revision).
REQ-002 SHALL have parameter TIMEOUT, default 200000, idle clk cycles after which a pending prefix is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  scan-code byte from the PS/2 receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port voice_key  output  32  packed key codes, voice v in bits [8v+7:8v].
REQ-008 SHALL have port voice_active  output  4  bit v set while voice v holds a key.
REQ-009 SHALL have port evt_valid  output  1  event FIFO non-empty.
REQ-010 SHALL have port evt_ready  input  1  consumer pops the head when evt_valid and evt_ready are both high.
REQ-011 SHALL have port evt_code  output  8  key code of the head event.
REQ-012 SHALL have port evt_press  output  1  head event: 1 press, 0 release.
REQ-013 SHALL have port evt_voice  output  2  voice index of the head event.
REQ-014 SHALL have port evt_steal  output  1  head press event reallocated a busy voice.
REQ-015 SHALL have port evt_overflow  output  1  sticky flag: an event was dropped.

Function
REQ-016 SHALL decode with an FSM of states IDLE, BRK, EXT, EXT_BRK.
REQ-017 IDLE: F0 -> BRK; E0 -> EXT; bytes 00, AA, E1, EE, FA, FC, FD, FE, FF are discarded; any other byte is a make code.
REQ-018 BRK: next byte is a break code -> IDLE.
REQ-019 EXT: F0 -> EXT_BRK; any other byte is discarded -> IDLE.
REQ-020 EXT_BRK: next byte is discarded -> IDLE; extended keys never touch the voice table.
REQ-021 In any non-IDLE state, TIMEOUT consecutive cycles without rx_valid SHALL force IDLE.
REQ-022 The timeout counter SHALL be 18 bits, cleared on every rx_valid, and SHALL saturate.
REQ-023 Make of a key already held in a voice (typematic repeat): no table change, no event.
REQ-024 Make of a new key with a free voice: lowest-index free voice allocated; press event pushed with evt_steal=0.
REQ-025 Make of a new key with all voices busy: the oldest voice is overwritten; press event pushed with evt_steal=1; no release event.
REQ-026 Age tracking: each voice has a 2-bit rank.
REQ-027 On allocation, the allocated voice's rank is set to 0 and every other active voice's rank increments, saturating at 3.
REQ-028 The oldest voice is the active voice with the highest rank; ties go to the lowest index.
REQ-029 Break of a held key: voice_active bit cleared; voice_key retains its value; release event pushed.
REQ-030 Break of a key that is not held: ignored.
REQ-031 Latency: a byte strobed in cycle N updates voice_* and the FIFO visibly in cycle N+1.
REQ-032 Event FIFO: 2 entries, registered outputs, first-word fall-through.
REQ-033 Push into a full FIFO with no pop in the same cycle: the event is dropped, evt_overflow set, and the voice table is still updated.
REQ-034 Push and pop in the same cycle when full: both succeed; no overflow.
REQ-035 Push and pop in the same cycle when empty: not possible; the push lands and evt_valid rises next cycle.
REQ-036 evt_code, evt_press, evt_voice and evt_steal SHALL be stable while evt_valid=1 and evt_ready=0.

Reset
REQ-037 rst_n low SHALL immediately set FSM=IDLE, timeout counter=0, voice_active=0, voice_key=0, all ranks=0, FIFO empty (evt_valid=0), evt_code/evt_press/evt_voice/evt_steal=0 and evt_overflow=0.
REQ-038 Reset mid-sequence, e.g. after F0 has been received, SHALL discard the pending prefix.
REQ-039 evt_overflow SHALL clear only on reset.

Structure
REQ-040 A shared package SHALL hold the scan-code constants (F0, E0 and the discard list), the FSM state encoding, and the NUM_VOICES and TIMEOUT defaults.
REQ-041 The 2-entry event FIFO SHALL be the single sub-module, ps2_evt_fifo.
REQ-042 The voice table, ranks and FSM SHALL live in the top module.

Verification
REQ-043 Bytes 1C, 1B with evt_ready=1 -> press events (1C, v0) and (1B, v1); voice_active=0011.
REQ-044 Bytes 1C, 1C, 1C (typematic repeat) -> exactly one press event.
REQ-045 Bytes F0, 1C after 1C is held -> release event (1C, v0); voice_active bit0=0.
REQ-046 Makes 15, 1D, 24, 2D, then 2C -> last event (2C, v0, steal=1); voice_key[7:0]=2C.
REQ-047 Bytes E0, 75, then E0, F0, 75 -> no events and no table change.
REQ-048 Hold evt_ready=0 and push 3 makes -> evt_valid=1, 2 entries retained, evt_overflow=1, voice_active=0111.
REQ-049 Send F0 and wait TIMEOUT+1 cycles, then 1C -> press event for 1C.
REQ-050 Send F0, pulse rst_n low, then 1C -> press event for 1C.
